// File: rtl/data_mem_port_pkg.sv
// Shared types for the data-memory port: FSM states,
// transfer sizes and the size-to-byte-mask helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_e;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  // Zero mask marks an unsupported size.
  function automatic logic [3:0] size_mask(
    input logic [2:0] sz
  );
    logic [3:0] m;
    case (sz)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// Request/response and SRAM signals of the data-memory port.
// slave = the port itself, master = controller plus SRAM.
interface data_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              load;
  logic              store;
  logic [2:0]        xfer_size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       MEM_wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rd_data;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, load, store,
    input  xfer_size, addr, MEM_wr_data,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid,
    output rd_data, rsp_err,
    output mem_en, mem_we, mem_addr,
    output mem_be, mem_wdata
  );

  modport master (
    output req_valid, load, store,
    output xfer_size, addr, MEM_wr_data,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid,
    input  rd_data, rsp_err,
    input  mem_en, mem_we, mem_addr,
    input  mem_be, mem_wdata
  );
endinterface

// File: rtl/data_mem_port_align.sv
// Byte-lane steering: store rotation, byte enables for both
// words, and right-justified zero-masked load extraction.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_wr,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [3:0]  o_be_lo,
  output logic [3:0]  o_be_hi,
  output logic        o_span,
  output logic [31:0] o_wd_lo,
  output logic [31:0] o_wd_hi,
  output logic [31:0] o_rd
);
  logic [3:0]  w_mask;
  logic [7:0]  w_lanes;
  logic [4:0]  w_sh;
  logic [5:0]  w_shr;
  logic [31:0] w_keep;

  assign w_mask  = size_mask(i_size);
  assign w_lanes = {4'b0000, w_mask} << i_off;
  assign o_be_lo = w_lanes[3:0];
  assign o_be_hi = w_lanes[7:4];
  assign o_span  = |w_lanes[7:4];

  assign w_sh  = {i_off, 3'b000};
  assign w_shr = 6'd32 - {1'b0, w_sh};

  assign o_wd_lo = i_wr << w_sh;
  assign o_wd_hi = i_wr >> w_shr;

  assign w_keep = {{8{w_mask[3]}}, {8{w_mask[2]}},
                   {8{w_mask[1]}}, {8{w_mask[0]}}};

  assign o_rd = w_keep & 32'({i_hi, i_lo} >> w_sh);
endmodule

// File: rtl/data_mem_port.sv
// Load/store port to a word-wide synchronous SRAM; splits
// word-spanning accesses into two SRAM cycles.
module data_mem_port
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic            clk,
  input logic            reset,
  data_mem_port_if.slave bus
);
  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic              r_load;
  logic              r_span;
  logic [31:0]       r_wr;
  logic [31:0]       r_lo;
  logic [31:0]       r_hi;
  logic              r_err;
  logic              r_fresh;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;

  logic              w_idle;
  logic              w_accept;
  logic              w_size_ok;
  logic [1:0]        w_off;
  logic [2:0]        w_size;
  logic [31:0]       w_wr;
  logic [31:0]       w_lo;
  logic [31:0]       w_hi;
  logic [3:0]        w_be_lo;
  logic [3:0]        w_be_hi;
  logic              w_span;
  logic [31:0]       w_wd_lo;
  logic [31:0]       w_wd_hi;
  logic [31:0]       w_rd;
  logic [ADDR_W-3:0] w_addr_hi;

  assign w_idle    = (r_state == IDLE);
  assign w_accept  = w_idle & bus.req_valid
                   & (bus.load | bus.store);
  assign w_size_ok = (size_mask(bus.xfer_size) != 4'b0000);

  // In IDLE the aligner sees the incoming request so the
  // LO strobe can be registered on the accept edge.
  assign w_off  = w_idle ? bus.addr[1:0]   : r_addr[1:0];
  assign w_size = w_idle ? bus.xfer_size   : r_size;
  assign w_wr   = w_idle ? bus.MEM_wr_data : r_wr;

  // First RESP cycle: the last read word is still on the bus.
  assign w_lo = (r_fresh & ~r_span) ? bus.mem_rdata : r_lo;
  assign w_hi = (r_fresh &  r_span) ? bus.mem_rdata : r_hi;

  assign w_addr_hi = r_addr[ADDR_W-1:2]
                   + {{(ADDR_W-3){1'b0}}, 1'b1};

  byte_lane_align u_align (
    .i_off   (w_off),
    .i_size  (w_size),
    .i_wr    (w_wr),
    .i_lo    (w_lo),
    .i_hi    (w_hi),
    .o_be_lo (w_be_lo),
    .o_be_hi (w_be_hi),
    .o_span  (w_span),
    .o_wd_lo (w_wd_lo),
    .o_wd_hi (w_wd_hi),
    .o_rd    (w_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_size      <= '0;
      r_load      <= 1'b0;
      r_span      <= 1'b0;
      r_wr        <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_err       <= 1'b0;
      r_fresh     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr <= bus.addr;
            r_size <= bus.xfer_size;
            r_load <= bus.load;
            r_wr   <= bus.MEM_wr_data;
            r_span <= w_span;
            if (w_size_ok) begin
              r_state     <= LO;
              r_mem_en    <= 1'b1;
              r_mem_we    <= ~bus.load;
              r_mem_addr  <= bus.addr[ADDR_W-1:2];
              r_mem_be    <= w_be_lo;
              r_mem_wdata <= w_wd_lo;
            end else begin
              r_state <= RESP;
              r_err   <= 1'b1;
            end
          end
        end
        LO: begin
          if (r_span) begin
            r_state     <= HI;
            r_mem_en    <= 1'b1;
            r_mem_we    <= ~r_load;
            r_mem_addr  <= w_addr_hi;
            r_mem_be    <= w_be_hi;
            r_mem_wdata <= w_wd_hi;
          end else begin
            r_state <= RESP;
            r_fresh <= r_load;
          end
        end
        HI: begin
          if (r_load) r_lo <= bus.mem_rdata;
          r_state <= RESP;
          r_fresh <= r_load;
        end
        RESP: begin
          if (r_fresh) begin
            if (r_span) r_hi <= bus.mem_rdata;
            else        r_lo <= bus.mem_rdata;
            r_fresh <= 1'b0;
          end
          if (bus.rsp_ready) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_idle;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_err   = r_err;
  assign bus.rd_data   =
    ((r_state == RESP) & r_load & ~r_err) ? w_rd : 32'h0;

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboard bench for data_mem_port: expected SRAM strobes
// and responses are queued by stimulus, popped by a monitor.
module tb_data_mem_port;
  logic clk;
  logic reset;

  data_mem_port_if #(.ADDR_W(32)) bus ();

  data_mem_port #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [29:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } mexp_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } rexp_t;

  mexp_t mq[$];
  rexp_t rq[$];
  mexp_t m_cur;
  rexp_t r_cur;

  logic [31:0] sram [logic [29:0]];

  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // SRAM model: one-cycle read latency, byte-enable writes.
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      logic [31:0] w;
      w = sram.exists(bus.mem_addr) ? sram[bus.mem_addr] : 32'h0;
      if (bus.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
        sram[bus.mem_addr] = w;
      end else begin
        bus.mem_rdata <= w;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (mq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_strobe: got addr %h want none",
                 bus.mem_addr);
      end else begin
        m_cur = mq.pop_front();
        chk("mem_addr", 64'(bus.mem_addr), 64'(m_cur.a));
        chk("mem_we", 64'(bus.mem_we), 64'(m_cur.we));
        chk("mem_be", 64'(bus.mem_be), 64'(m_cur.be));
        if (m_cur.we)
          chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_cur.wd));
      end
    end
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (rq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_rsp: got rd %h want none",
                 bus.rd_data);
      end else begin
        r_cur = rq.pop_front();
        chk("rd_data", 64'(bus.rd_data), 64'(r_cur.rd));
        chk("rsp_err", 64'(bus.rsp_err), 64'(r_cur.err));
      end
    end
  end

  function automatic void exp_m(input logic [29:0] a,
                                input logic we,
                                input logic [3:0] be,
                                input logic [31:0] wd);
    mexp_t e;
    e.a = a; e.we = we; e.be = be; e.wd = wd;
    mq.push_back(e);
  endfunction

  // Called at posedge+1 with the DUT idle.
  task automatic xact(input logic ld, input logic st,
                      input logic [2:0] sz,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] e_rd,
                      input logic e_err,
                      input int lat, input int hold);
    rexp_t e;
    int n;
    e.rd = e_rd; e.err = e_err;
    rq.push_back(e);
    bus.req_valid   = 1'b1;
    bus.load        = ld;
    bus.store       = st;
    bus.xfer_size   = sz;
    bus.addr        = a;
    bus.MEM_wr_data = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.load      = 1'b0;
    bus.store     = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rd", 64'(bus.rd_data), 64'(e_rd));
      chk("hold_err", 64'(bus.rsp_err), 64'(e_err));
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_mem_en", 64'(bus.mem_en), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("idle_after_rsp", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.load        = 1'b0;
    bus.store       = 1'b0;
    bus.xfer_size   = 3'd0;
    bus.addr        = 32'h0;
    bus.MEM_wr_data = 32'h0;
    bus.rsp_ready   = 1'b0;
    bus.mem_rdata   = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_be", 64'(bus.mem_be), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);

    @(posedge clk); #1;

    exp_m(30'h40, 1'b1, 4'b1111, 32'hDEADBEEF);
    xact(0, 1, 3'd4, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 0);
    exp_m(30'h40, 1'b0, 4'b1111, 32'h0);
    xact(1, 0, 3'd4, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0);

    exp_m(30'h40, 1'b1, 4'b1000, 32'hA5000000);
    xact(0, 1, 3'd1, 32'h103, 32'h000000A5, 32'h0, 0, 2, 0);
    exp_m(30'h40, 1'b0, 4'b1000, 32'h0);
    xact(1, 0, 3'd1, 32'h103, 32'h0, 32'h000000A5, 0, 2, 0);

    // Load-and-store both high acts as a load.
    exp_m(30'h40, 1'b0, 4'b0011, 32'h0);
    xact(1, 1, 3'd2, 32'h100, 32'h0, 32'h0000BEEF, 0, 2, 1);

    sram[30'h3F] = 32'hAB000000;
    sram[30'h40] = 32'h000000CD;
    exp_m(30'h3F, 1'b0, 4'b1000, 32'h0);
    exp_m(30'h40, 1'b0, 4'b0001, 32'h0);
    xact(1, 0, 3'd2, 32'h0FF, 32'h0, 32'h0000CDAB, 0, 3, 0);

    exp_m(30'h3FFFFFFF, 1'b1, 4'b1100, 32'h33440000);
    exp_m(30'h0, 1'b1, 4'b0011, 32'h00001122);
    xact(0, 1, 3'd4, 32'hFFFFFFFE, 32'h11223344,
         32'h0, 0, 3, 0);
    exp_m(30'h3FFFFFFF, 1'b0, 4'b1100, 32'h0);
    exp_m(30'h0, 1'b0, 4'b0011, 32'h0);
    xact(1, 0, 3'd4, 32'hFFFFFFFE, 32'h0,
         32'h11223344, 0, 3, 2);

    exp_m(30'h3F, 1'b0, 4'b1100, 32'h0);
    xact(1, 0, 3'd2, 32'h0FE, 32'h0, 32'h0000AB00, 0, 2, 0);

    xact(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 1, 1, 5);

    bus.req_valid = 1'b1;
    bus.xfer_size = 3'd4;
    bus.addr      = 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("noop_req_ready", 64'(bus.req_ready), 64'd1);
      chk("noop_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    bus.req_valid = 1'b0;

    exp_m(30'h3F, 1'b0, 4'b1000, 32'h0);
    exp_m(30'h40, 1'b0, 4'b0001, 32'h0);
    bus.req_valid = 1'b1;
    bus.load      = 1'b1;
    bus.xfer_size = 3'd2;
    bus.addr      = 32'h0FF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.load      = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_mem_en", 64'(bus.mem_en), 64'd0);
    @(posedge clk); #1;

    exp_m(30'h40, 1'b0, 4'b1111, 32'h0);
    xact(1, 0, 3'd4, 32'h100, 32'h0, 32'h000000CD, 0, 2, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("mem_queue_empty", 64'(mq.size()), 64'd0);
    chk("rsp_queue_empty", 64'(rq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
